// File: rtl/blink_code_arbiter.sv
// blink_code_arbiter
//   Lets several status sources share one board LED. Each source asks for a
//   blink code: N pulses, then a pause. The lowest requesting index wins. Its
//   code is played out on a prescaled tick base. When the pause ends, the block
//   returns to IDLE and arbitrates again in that same IDLE cycle.
//
//   Ports
//     clk    in   system clock
//     rst    in   synchronous, active-high reset; aborts a running sequence
//     req    in   [NUM_REQ] level requests, sampled only at grant
//     code   in   [NUM_REQ*CODE_WIDTH] pulse counts, requester i uses slice i
//     led    out  LED drive, high only in ON
//     grant  out  [NUM_REQ] one-hot owner, stable for the whole sequence
//     busy   out  high while a sequence is running
//     done   out  one-cycle pulse on the return to IDLE
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no sequence; arbitrate on any non-zero req
//   ON    | LED lit for ON_TICKS ticks; pulse count drops at the end
//   OFF   | LED dark for OFF_TICKS ticks between pulses
//   GAP   | LED dark for GAP_TICKS ticks after the last pulse

module blink_code_arbiter #(
   parameter int DIVIDER    = 100000,
   parameter int NUM_REQ    = 4,
   parameter int CODE_WIDTH = 4,
   parameter int ON_TICKS   = 2,
   parameter int OFF_TICKS  = 3,
   parameter int GAP_TICKS  = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*CODE_WIDTH-1:0]   code,
   output logic                            led,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            busy,
   output logic                            done
);

   localparam int MAX_T0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int MAX_T  = (MAX_T0 > GAP_TICKS) ? MAX_T0 : GAP_TICKS;
   localparam int PH_W   = $clog2(MAX_T + 1);
   localparam int PRE_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

   localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DIVIDER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [PRE_W-1:0]        pre_cnt;
   logic [PH_W-1:0]         ph_cnt;
   logic [CODE_WIDTH-1:0]   pulse_cnt;

   logic                    led_nxt, busy_nxt, done_nxt;
   logic [NUM_REQ-1:0]      grant_nxt;

   logic                    tick, phase_last, arb;
   logic [NUM_REQ-1:0]      win_onehot;
   logic [CODE_WIDTH-1:0]   win_code;

   // Downward scan so the lowest set index is the one left standing.
   always_comb begin
      win_onehot = '0;
      win_code   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_onehot    = '0;
            win_onehot[i] = 1'b1;
            win_code      = code[i*CODE_WIDTH +: CODE_WIDTH];
         end
      end
   end

   assign arb        = (state == S_IDLE) && (|req);
   assign tick       = (state != S_IDLE) && (pre_cnt == '0);
   assign phase_last = tick && (ph_cnt == PH_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (arb) state_nxt = (win_code == '0) ? S_GAP : S_ON;
         S_ON:   if (phase_last)
                    state_nxt = (pulse_cnt == CODE_WIDTH'(1)) ? S_GAP : S_OFF;
         S_OFF:  if (phase_last) state_nxt = S_ON;
         S_GAP:  if (phase_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: next values, registered below so every output is a flop.
   always_comb begin
      led_nxt   = (state_nxt == S_ON);
      busy_nxt  = (state_nxt != S_IDLE);
      done_nxt  = (state == S_GAP) && (state_nxt == S_IDLE);
      grant_nxt = grant;
      if (arb)                       grant_nxt = win_onehot;
      else if (state_nxt == S_IDLE)  grant_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led   <= 1'b0;
         grant <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         led   <= led_nxt;
         grant <= grant_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Prescaler held at reload in IDLE, so the first tick of a sequence lands
   // exactly DIVIDER cycles after it starts.
   always_ff @(posedge clk) begin
      if (rst)                   pre_cnt <= '0;
      else if (state == S_IDLE)  pre_cnt <= PRE_RELOAD;
      else if (pre_cnt == '0)    pre_cnt <= PRE_RELOAD;
      else                       pre_cnt <= pre_cnt - PRE_W'(1);
   end

   // Phase counter holds the ticks left in the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         ph_cnt <= '0;
      end else if (state_nxt != state) begin
         case (state_nxt)
            S_ON:    ph_cnt <= PH_W'(ON_TICKS);
            S_OFF:   ph_cnt <= PH_W'(OFF_TICKS);
            S_GAP:   ph_cnt <= PH_W'(GAP_TICKS);
            default: ph_cnt <= '0;
         endcase
      end else if (tick) begin
         ph_cnt <= ph_cnt - PH_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                          pulse_cnt <= '0;
      else if (arb)                     pulse_cnt <= win_code;
      else if (state == S_ON && phase_last)
                                        pulse_cnt <= pulse_cnt - CODE_WIDTH'(1);
   end

endmodule
